// File: rtl/zimbo_muldiv_if.sv
// zimbo_muldiv_if: start/busy/done handshake and result bus of the multiply/divide unit
interface zimbo_muldiv_if #(parameter int WIDTH = 16);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;
    logic             sign;
    logic             zero;
    modport master (output start, op, opa, opb,
                    input busy, done, result_hi, result_lo, div_by_zero, sign, zero);
    modport slave  (input start, op, opa, opb,
                    output busy, done, result_hi, result_lo, div_by_zero, sign, zero);
endinterface

// File: rtl/zimbo_muldiv.sv
// zimbo_muldiv: iterative signed/unsigned shift-add multiply and restoring divide.
// Optional MULDIV_EARLY_OUT_EN ends MUL once the multiplier is exhausted and skips CALC on DIV by zero.
module zimbo_muldiv #(parameter int WIDTH = 16) (
    input logic           clock,
    input logic           reset,
    zimbo_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   opa_q, opa_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] p_q, p_d, x_q, x_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic               sign_q, sign_d, zero_q, zero_d;
    logic               accept, last, dz;
    logic [WIDTH-1:0]   ua, ub, quo, rem;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opa_d   = opa_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        accept  = bus.start && !busy_q;
        ua      = (bus.op[0] && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
        ub      = (bus.op[0] && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
        // p_q holds {remainder, dividend/quotient}; x_q[WIDTH-1:0] holds the divisor
        trial   = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, x_q[WIDTH-1:0]};
`ifdef MULDIV_EARLY_OUT_EN
        last    = (cnt_q == CW'(1)) || (!op_q[1] && y_q[WIDTH-1:1] == '0);
`else
        last    = cnt_q == CW'(1);
`endif
        dz      = x_q[WIDTH-1:0] == '0;
        prod    = (op_q[0] && (sa_q ^ sb_q)) ? -p_q : p_q;
        quo     = dz ? '1 : (op_q[0] && (sa_q ^ sb_q)) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem     = dz ? opa_q : (op_q[0] && sa_q) ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        case (state_q)
            CALC: begin
                cnt_d   = cnt_q - CW'(1);
                p_d     = op_q[1] ? (trial[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0}
                                                  : {trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1})
                                  : p_q + (y_q[0] ? x_q : '0);
                x_d     = op_q[1] ? x_q : x_q << 1;
                y_d     = y_q >> 1;
                state_d = last ? FIX : CALC;
            end
            FIX: begin
                hi_d    = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = op_q[1] ? quo : prod[WIDTH-1:0];
                sign_d  = lo_d[WIDTH-1];
                zero_d  = lo_d == '0;
                dz_d    = op_q[1] && dz;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            op_d    = bus.op;
            opa_d   = bus.opa;
            sa_d    = bus.op[0] && bus.opa[WIDTH-1];
            sb_d    = bus.op[0] && bus.opb[WIDTH-1];
            cnt_d   = CW'(WIDTH);
            p_d     = bus.op[1] ? {{WIDTH{1'b0}}, ua} : '0;
            x_d     = {{WIDTH{1'b0}}, bus.op[1] ? ub : ua};
            y_d     = ub;
            busy_d  = 1'b1;
            dz_d    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            state_d = (bus.op[1] && bus.opb == '0) ? FIX : CALC;
`else
            state_d = CALC;
`endif
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opa_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opa_q   <= opa_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
        end
    end
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result_hi   = hi_q;
    assign bus.result_lo   = lo_q;
    assign bus.div_by_zero = dz_q;
    assign bus.sign        = sign_q;
    assign bus.zero        = zero_q;
endmodule

// File: tb/tb_zimbo_muldiv.sv
// tb_zimbo_muldiv: directed checks of zimbo_muldiv at WIDTH=16
module tb_zimbo_muldiv;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   done_seen;
    zimbo_muldiv_if #(.WIDTH(16)) bus ();
    zimbo_muldiv #(.WIDTH(16)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask
    task automatic run(input string tag, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] hi, input logic [15:0] lo,
                       input logic dz, input int lat);
        int l;
        issue(o, a, b);
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(l);
        chk({tag, " latency"}, 32'(l), 32'(lat));
        chk({tag, " hi"}, 32'(bus.result_hi), 32'(hi));
        chk({tag, " lo"}, 32'(bus.result_lo), 32'(lo));
        chk({tag, " dz"}, 32'(bus.div_by_zero), 32'(dz));
        chk({tag, " sign"}, 32'(bus.sign), 32'(lo[15]));
        chk({tag, " zero"}, 32'(bus.zero), 32'(lo == 16'h0));
        chk({tag, " busy_done"}, 32'(bus.busy), 32'd0);
        @(posedge clock); #1;
        chk({tag, " done_width"}, 32'(bus.done), 32'd0);
    endtask
    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.opa = '0; bus.opb = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst res", {bus.result_hi, bus.result_lo}, 32'h0);
        chk("rst flags", {29'h0, bus.div_by_zero, bus.sign, bus.zero}, 32'h0);
        run("mulu_max", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 18);
        issue(2'b00, 16'h1234, 16'h00FF);
        @(posedge clock);
        @(posedge clock); #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.opa = 16'h0009; bus.opb = 16'h0003;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk("abort busy_mid", 32'(bus.busy), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort res", {bus.result_hi, bus.result_lo}, 32'h0);
        chk("abort flags", {28'h0, bus.done, bus.div_by_zero, bus.sign, bus.zero}, 32'h0);
        done_seen = 0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clock); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("abort quiet", 32'(done_seen), 32'd0);
        run("muls", 2'b01, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0, EO ? 5 : 18);
        run("divs", 2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 18);
        run("divu_z", 2'b10, 16'h0005, 16'h0000, 16'h0005, 16'hFFFF, 1'b1, EO ? 2 : 18);
        run("divu", 2'b10, 16'h0009, 16'h0003, 16'h0000, 16'h0003, 1'b0, 18);
        run("divs_z", 2'b11, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1, EO ? 2 : 18);
        run("divs_min", 2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18);
        run("mulu_0", 2'b00, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, EO ? 3 : 18);
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b00; bus.opa = 16'h0003; bus.opb = 16'h0002;
        @(posedge clock); #1;
        bus.op = 2'b10; bus.opa = 16'h0064; bus.opb = 16'h0000;
        wait_done(n);
        chk("b2b lat1", 32'(n), EO ? 32'd4 : 32'd18);
        chk("b2b res1", {bus.result_hi, bus.result_lo}, 32'h0000_0006);
        chk("b2b busy2", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(n);
        chk("b2b lat2", 32'(n), EO ? 32'd2 : 32'd18);
        chk("b2b res2", {bus.result_hi, bus.result_lo}, 32'h0064_FFFF);
        chk("b2b dz2", 32'(bus.div_by_zero), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
